// File: rtl/pim_pkg.sv
// Shared definitions for the PIM operand path: loader state encoding,
// default geometry and the size-field width helper.
package pim_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_MAX_SIZE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_FIRE,
        ST_WAIT
    } loader_state_e;

    function automatic int size_w(input int max_size);
        return $clog2(max_size + 1);
    endfunction

endpackage

// File: rtl/pim_matrix_loader_if.sv
// Element stream into the matrix loader: one operand element per accepted beat.
interface pim_matrix_loader_if #(
    parameter int WIDTH = pim_pkg::DEF_WIDTH
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/pim_elem_counter.sv
// Loadable element index counter; tc flags the last element (limit-1) and the
// next increment folds back to zero instead of running past the matrix.
module pim_elem_counter #(
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic [IW:0]   limit,
    output logic [IW-1:0] idx,
    output logic          tc
);

    logic [IW-1:0] idx_q;

    assign idx = idx_q;
    assign tc  = ({1'b0, idx_q} == (limit - (IW+1)'(1)));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx_q <= '0;
        end else if (inc) begin
            idx_q <= tc ? '0 : idx_q + IW'(1);
        end
    end

endmodule

// File: rtl/pim_matrix_loader.sv
// Assembles the A then B element stream into the flat operand arrays, fires
// the controller once, then holds operands until the result is reported.
module pim_matrix_loader
    import pim_pkg::*;
#(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  MAX_SIZE = DEF_MAX_SIZE,
    localparam int SZW      = size_w(MAX_SIZE),
    localparam int NE       = MAX_SIZE * MAX_SIZE,
    localparam int IW       = $clog2(NE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_go,
    input  logic [SZW-1:0]             cfg_size,
    pim_matrix_loader_if.slave         in_bus,
    output logic [NE-1:0][WIDTH-1:0]   matrix_A,
    output logic [NE-1:0][WIDTH-1:0]   matrix_B,
    output logic                       start,
    input  logic                       result_ready,
    output logic                       busy,
    output logic                       err
);

    loader_state_e state_q, state_d;
    logic          ready;
    logic          size_ok;
    logic          go;
    logic          beat;
    logic          last;
    logic          err_q;
    logic [IW:0]   nn_q;
    logic [IW-1:0] idx;

    assign size_ok = (cfg_size != '0) && (cfg_size <= SZW'(MAX_SIZE));
    assign go      = (state_q == ST_IDLE) && load_go && size_ok;
    assign beat    = ready && in_bus.in_valid;

    assign in_bus.in_ready = ready;
    assign busy            = (state_q != ST_IDLE);
    assign err             = err_q;

    pim_elem_counter #(.IW(IW)) u_idx (
        .clk   (clk),
        .rst   (rst),
        .clr   (go),
        .inc   (beat),
        .limit (nn_q),
        .idx   (idx),
        .tc    (last)
    );

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                ready = 1'b1;
                if (beat && last) state_d = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                ready = 1'b1;
                if (beat && last) state_d = ST_FIRE;
            end
            ST_FIRE: begin
                start   = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (result_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            nn_q     <= '0;
            matrix_A <= '0;
            matrix_B <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == ST_IDLE) && load_go && !size_ok;
            if (go) begin
                // N*N fixed for the whole transaction; stale operands cleared
                nn_q     <= (IW+1)'(cfg_size) * (IW+1)'(cfg_size);
                matrix_A <= '0;
                matrix_B <= '0;
            end else if (beat) begin
                if (state_q == ST_LOAD_A) matrix_A[idx] <= in_bus.in_data;
                else                      matrix_B[idx] <= in_bus.in_data;
            end
        end
    end

endmodule

// File: tb/tb_pim_matrix_loader.sv
// Self-checking bench for pim_matrix_loader: directed scenarios plus random
// loads compared against an operand-array reference built from the beat list.
module tb_pim_matrix_loader;
    import pim_pkg::*;

    localparam int WIDTH    = 32;
    localparam int MAX_SIZE = 16;
    localparam int SZW      = size_w(MAX_SIZE);
    localparam int NE       = MAX_SIZE * MAX_SIZE;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     load_go;
    logic [SZW-1:0]           cfg_size;
    logic                     result_ready;
    logic [NE-1:0][WIDTH-1:0] matrix_A;
    logic [NE-1:0][WIDTH-1:0] matrix_B;
    logic                     start;
    logic                     busy;
    logic                     err;

    pim_matrix_loader_if #(.WIDTH(WIDTH)) bus ();

    pim_matrix_loader #(.WIDTH(WIDTH), .MAX_SIZE(MAX_SIZE)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_go      (load_go),
        .cfg_size     (cfg_size),
        .in_bus       (bus.slave),
        .matrix_A     (matrix_A),
        .matrix_B     (matrix_B),
        .start        (start),
        .result_ready (result_ready),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] exp_a [NE];
    logic [WIDTH-1:0] exp_b [NE];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NE; k++) begin
            exp_a[k] = '0;
            exp_b[k] = '0;
        end
    endtask

    task automatic check_arrays(input string tag);
        for (int k = 0; k < NE; k++) begin
            chk($sformatf("%s_A[%0d]", tag, k), matrix_A[k], exp_a[k]);
            chk($sformatf("%s_B[%0d]", tag, k), matrix_B[k], exp_b[k]);
        end
    endtask

    // mode 0: sequential values, no bubbles; 1: valid every other cycle;
    // 2: random values with random bubbles. abort_at >= 0 pulses rst after
    // that many accepted beats. Returns in WAIT unless aborted.
    task automatic do_load(input int n, input int mode, input int abort_at, input bit rr_in_fire);
        int               nn;
        int               cnt;
        int               edges;
        bit               v;
        logic [WIDTH-1:0] vals [$];
        nn  = n * n;
        cnt = 0;
        for (int k = 0; k < 2 * nn; k++)
            vals.push_back(mode == 0 ? WIDTH'(k + 1) : WIDTH'($urandom()));

        @(negedge clk);
        load_go  = 1'b1;
        cfg_size = SZW'(n);
        @(negedge clk);
        load_go = 1'b0;
        edges   = 1;
        chk("busy_after_go", 32'(busy), 1);
        chk("err_on_go", 32'(err), 0);
        clear_model();

        while (cnt < 2 * nn && edges < 8 * nn + 40) begin
            chk("in_ready_load", 32'(bus.in_ready), 1);
            chk("start_early", 32'(start), 0);
            if (cnt == abort_at) begin
                rst          = 1'b1;
                bus.in_valid = 1'b1;
                bus.in_data  = $urandom();
                @(negedge clk);
                rst = 1'b0;
                clear_model();
                chk("abort_in_ready", 32'(bus.in_ready), 0);
                chk("abort_start", 32'(start), 0);
                chk("abort_busy", 32'(busy), 0);
                chk("abort_err", 32'(err), 0);
                check_arrays("abort");
                repeat (5) begin
                    @(negedge clk);
                    chk("abort_no_start", 32'(start), 0);
                    chk("abort_idle_ready", 32'(bus.in_ready), 0);
                end
                bus.in_valid = 1'b0;
                return;
            end
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (edges % 2 == 1);
            else                v = ($urandom_range(0, 3) != 0);
            bus.in_valid = v;
            bus.in_data  = v ? vals[cnt] : WIDTH'($urandom());
            @(negedge clk);
            edges++;
            if (v) begin
                if (cnt < nn) begin
                    exp_a[cnt] = vals[cnt];
                    chk("elem_A_visible", matrix_A[cnt], exp_a[cnt]);
                end else begin
                    exp_b[cnt - nn] = vals[cnt];
                    chk("elem_B_visible", matrix_B[cnt - nn], exp_b[cnt - nn]);
                end
                cnt++;
            end
        end
        bus.in_valid = 1'b0;

        chk("load_timeout", 32'(cnt), 32'(2 * nn));
        chk("start_pulse", 32'(start), 1);
        chk("fire_in_ready", 32'(bus.in_ready), 0);
        chk("fire_busy", 32'(busy), 1);
        // load_go cycle through start cycle inclusive spans 2*N*N+2 cycles
        if (mode == 0) chk("go_to_start_edges", 32'(edges), 32'(2 * nn + 1));
        check_arrays("load");

        result_ready = rr_in_fire;
        @(negedge clk);
        result_ready = 1'b0;
        chk("start_one_cycle", 32'(start), 0);
        chk("wait_busy", 32'(busy), 1);
    endtask

    task automatic wait_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            load_go      = 1'b1;
            cfg_size     = SZW'($urandom_range(0, 31));
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom();
            @(negedge clk);
            chk("wait_err", 32'(err), 0);
            chk("wait_in_ready", 32'(bus.in_ready), 0);
            chk("wait_busy_hold", 32'(busy), 1);
            chk("wait_start", 32'(start), 0);
        end
        load_go      = 1'b0;
        bus.in_valid = 1'b0;
        check_arrays("wait");
    endtask

    task automatic release_op();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("release_busy", 32'(busy), 0);
        chk("release_in_ready", 32'(bus.in_ready), 0);
        check_arrays("release");
    endtask

    task automatic bad_size(input int s);
        load_go  = 1'b1;
        cfg_size = SZW'(s);
        @(negedge clk);
        load_go = 1'b0;
        chk("bad_err", 32'(err), 1);
        chk("bad_busy", 32'(busy), 0);
        chk("bad_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        chk("bad_err_pulse", 32'(err), 0);
        chk("bad_busy_after", 32'(busy), 0);
        check_arrays("bad_size");
    endtask

    initial begin
        rst          = 1'b1;
        load_go      = 1'b0;
        cfg_size     = '0;
        result_ready = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        check_arrays("rst");

        do_load(2, 0, -1, 1'b0);
        wait_phase(4);
        release_op();

        bad_size(0);
        bad_size(17);
        bad_size(31);

        do_load(1, 0, -1, 1'b1);
        release_op();

        do_load(3, 1, -1, 1'b0);
        release_op();

        do_load(4, 0, 20, 1'b0);

        do_load(16, 0, -1, 1'b0);
        release_op();

        for (int i = 0; i < 6; i++) begin
            do_load($urandom_range(1, MAX_SIZE), 2, -1, 1'($urandom_range(0, 1)));
            release_op();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
